// File: rtl/buton_okuyucu.sv
// buton_okuyucu: per-button synchronizer, debouncer and press/hold FSM.
// Turns raw push-buttons into a clean debounced level plus one-cycle pulses.
// Ports:
//   clk_i      system clock
//   rst_ni     synchronous active-low reset
//   btn_i      raw asynchronous buttons, active-high
//   level_o    debounced level per button
//   press_o    one-cycle pulse on debounced rise
//   release_o  one-cycle pulse on debounced fall
//   long_o     one-cycle pulse after LONG_CYCLES of continuous hold
//   repeat_o   one-cycle pulse every REPEAT_CYCLES after long_o while held
//   event_o    OR of every pulse output in the same cycle
module buton_okuyucu #(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1250000,
  parameter int unsigned LONG_CYCLES     = 125000000,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] level_o,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic [N_BTN-1:0] long_o,
  output logic [N_BTN-1:0] repeat_o,
  output logic             event_o
);

  localparam int unsigned DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [1:0] ST_RELEASED = 2'd0;
  localparam logic [1:0] ST_PRESSED  = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;

  logic [N_BTN-1:0] w_pulse_any;
  logic             r_event;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic              r_s1;
    logic              r_s2;
    logic              r_level;
    logic [DEB_W-1:0]  r_deb_cnt;
    logic [1:0]        r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_press;
    logic              r_release;
    logic              r_long;
    logic              r_repeat;

    logic [1:0]        w_state_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              w_press_nxt;
    logic              w_release_nxt;
    logic              w_long_nxt;
    logic              w_repeat_nxt;

    // Synchronizer and debouncer: level flips on the DEBOUNCE_CYCLES-th consecutive disagreement.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_s1      <= 1'b0;
        r_s2      <= 1'b0;
        r_level   <= 1'b0;
        r_deb_cnt <= '0;
      end else begin
        r_s1 <= btn_i[g];
        r_s2 <= r_s1;
        if (r_s2 != r_level) begin
          if (r_deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
            r_level   <= ~r_level;
            r_deb_cnt <= '0;
          end else begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
          end
        end else begin
          r_deb_cnt <= '0;
        end
      end
    end

    // FSM state, hold counter and registered pulses.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_state    <= ST_RELEASED;
        r_hold_cnt <= '0;
        r_press    <= 1'b0;
        r_release  <= 1'b0;
        r_long     <= 1'b0;
        r_repeat   <= 1'b0;
      end else begin
        r_state    <= w_state_nxt;
        r_hold_cnt <= w_hold_nxt;
        r_press    <= w_press_nxt;
        r_release  <= w_release_nxt;
        r_long     <= w_long_nxt;
        r_repeat   <= w_repeat_nxt;
      end
    end

    // Next state; a falling level is checked first so release beats long/repeat.
    always_comb begin
      w_state_nxt   = r_state;
      w_hold_nxt    = r_hold_cnt;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      w_long_nxt    = 1'b0;
      w_repeat_nxt  = 1'b0;
      case (r_state)
        ST_RELEASED: begin
          if (r_level) begin
            w_state_nxt = ST_PRESSED;
            w_hold_nxt  = '0;
            w_press_nxt = 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!r_level) begin
            w_state_nxt   = ST_RELEASED;
            w_hold_nxt    = '0;
            w_release_nxt = 1'b1;
          end else if (r_hold_cnt == HOLD_W'(LONG_CYCLES - 1)) begin
            w_state_nxt = ST_HELD;
            w_hold_nxt  = '0;
            w_long_nxt  = 1'b1;
          end else begin
            w_hold_nxt = r_hold_cnt + HOLD_W'(1);
          end
        end
        ST_HELD: begin
          if (!r_level) begin
            w_state_nxt   = ST_RELEASED;
            w_hold_nxt    = '0;
            w_release_nxt = 1'b1;
          end else if (r_hold_cnt == HOLD_W'(REPEAT_CYCLES - 1)) begin
            w_hold_nxt   = '0;
            w_repeat_nxt = 1'b1;
          end else begin
            w_hold_nxt = r_hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_RELEASED;
          w_hold_nxt  = '0;
        end
      endcase
    end

    assign w_pulse_any[g] = w_press_nxt | w_release_nxt | w_long_nxt | w_repeat_nxt;

    assign level_o[g]   = r_level;
    assign press_o[g]   = r_press;
    assign release_o[g] = r_release;
    assign long_o[g]    = r_long;
    assign repeat_o[g]  = r_repeat;
  end

  // event_o is registered from the same next-pulse terms so it lines up with the pulses.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_event <= 1'b0;
    end else begin
      r_event <= |w_pulse_any;
    end
  end

  assign event_o = r_event;

endmodule
